// File: rtl/control_unit_if.sv
// ----------------------------------------------------------------------------
// control_unit_if
//   Bundles the controller's instruction-ROM, data-RAM, register-file, ALU and
//   debug signals into one bus.
//   master : the controller (drives addresses/strobes/selects, reads im_data)
//   slave  : the datapath/ROM side (drives im_data, observes everything else)
//   Signals:
//     im_data    ROM data, combinational read of im_addr
//     im_addr    ROM address (= PC)
//     d_addr     data RAM address; d_wr data RAM write strobe
//     rf_ra_*    register file port A read address/enable
//     rf_rb_*    register file port B read address/enable
//     rf_w_*     register file write address/strobe
//     rf_s       write-data mux: 0 = ALU result, 1 = data RAM read data
//     alu_s0     ALU function select
//     halted     high while in HALT
//     state_dbg  current state encoding; ir_out IR contents
// ----------------------------------------------------------------------------
interface control_unit_if #(
    parameter int PC_BITS    = 7,
    parameter int INSTR_BITS = 16
);
    logic [INSTR_BITS-1:0] im_data;
    logic [PC_BITS-1:0]    im_addr;
    logic [7:0]            d_addr;
    logic                  d_wr;
    logic [3:0]            rf_ra_addr;
    logic                  rf_ra_rd;
    logic [3:0]            rf_rb_addr;
    logic                  rf_rb_rd;
    logic [3:0]            rf_w_addr;
    logic                  rf_w_wr;
    logic                  rf_s;
    logic [2:0]            alu_s0;
    logic                  halted;
    logic [3:0]            state_dbg;
    logic [INSTR_BITS-1:0] ir_out;

    modport master (
        input  im_data,
        output im_addr, d_addr, d_wr, rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd,
               rf_w_addr, rf_w_wr, rf_s, alu_s0, halted, state_dbg, ir_out
    );

    modport slave (
        output im_data,
        input  im_addr, d_addr, d_wr, rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd,
               rf_w_addr, rf_w_wr, rf_s, alu_s0, halted, state_dbg, ir_out
    );
endinterface

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//   Multicycle controller for the 16-bit datapath: fetches from the
//   instruction ROM, decodes, and sequences register-file, data-RAM and ALU
//   strobes. PC and IR live here.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      control_unit_if.master (ROM, RAM, RF, ALU and debug signals)
//   Instruction format: {op[15:12], f1[11:8], f2[7:4], f3[3:0]}.
//   All outputs are Moore (state + IR); write strobes are additionally gated
//   by reset_n so nothing is written while reset is held.
// ----------------------------------------------------------------------------
module control_unit #(
    parameter int PC_BITS    = 7,
    parameter int INSTR_BITS = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    control_unit_if.master bus
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD_A = 4'd3;
    localparam logic [3:0] S_LOAD_B = 4'd4;
    localparam logic [3:0] S_STORE  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_INC   = 4'b1001;
    localparam logic [3:0] OP_MOV   = 4'b1010;

    logic [3:0]            state_q, state_d;
    logic [PC_BITS-1:0]    pc_q, pc_d;
    logic [INSTR_BITS-1:0] ir_q, ir_d;

    logic [3:0] op;
    assign op = ir_q[15:12];

    // ALU select for an opcode; 0 for anything that is not an ALU op, which
    // doubles as the "is ALU op" test in DECODE.
    function automatic logic [2:0] alu_sel(input logic [3:0] opc);
        case (opc)
            OP_ADD:  alu_sel = 3'd1;
            OP_SUB:  alu_sel = 3'd2;
            OP_MOV:  alu_sel = 3'd3;
            OP_XOR:  alu_sel = 3'd4;
            OP_OR:   alu_sel = 3'd5;
            OP_AND:  alu_sel = 3'd6;
            OP_INC:  alu_sel = 3'd7;
            default: alu_sel = 3'd0;
        endcase
    endfunction

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.im_data;
                pc_d    = pc_q + PC_BITS'(1);   // wraps naturally
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_LOAD)             state_d = S_LOAD_A;
                else if (op == OP_STORE)       state_d = S_STORE;
                else if (op == OP_HALT)        state_d = S_HALT;
                else if (alu_sel(op) != 3'd0)  state_d = S_EXEC;
                else                           state_d = S_FETCH;  // NOOP / illegal
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_EXEC:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;          // unused encodings recover
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // ---------------- Moore outputs ----------------
    logic       d_wr_raw, rf_w_wr_raw;
    logic [7:0] d_addr;
    logic [3:0] ra_addr, rb_addr, w_addr;
    logic       ra_rd, rb_rd, rf_s, halted;
    logic [2:0] alu_s0;

    always_comb begin
        d_addr      = '0;
        d_wr_raw    = 1'b0;
        ra_addr     = '0;
        ra_rd       = 1'b0;
        rb_addr     = '0;
        rb_rd       = 1'b0;
        w_addr      = '0;
        rf_w_wr_raw = 1'b0;
        rf_s        = 1'b0;
        alu_s0      = '0;
        halted      = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                // RAM read is registered; data appears in LOAD_B
                d_addr = ir_q[11:4];
                rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                d_addr      = ir_q[11:4];
                rf_s        = 1'b1;
                w_addr      = ir_q[3:0];
                rf_w_wr_raw = 1'b1;
            end
            S_STORE: begin
                d_addr   = ir_q[11:4];
                ra_addr  = ir_q[3:0];
                ra_rd    = 1'b1;
                d_wr_raw = 1'b1;
            end
            S_EXEC: begin
                ra_addr     = ir_q[11:8];
                ra_rd       = 1'b1;
                rb_addr     = ir_q[7:4];
                rb_rd       = 1'b1;
                alu_s0      = alu_sel(op);
                w_addr      = ir_q[3:0];
                rf_w_wr_raw = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.im_addr    = pc_q;
    assign bus.d_addr     = d_addr;
    assign bus.d_wr       = d_wr_raw & reset_n;
    assign bus.rf_ra_addr = ra_addr;
    assign bus.rf_ra_rd   = ra_rd;
    assign bus.rf_rb_addr = rb_addr;
    assign bus.rf_rb_rd   = rb_rd;
    assign bus.rf_w_addr  = w_addr;
    assign bus.rf_w_wr    = rf_w_wr_raw & reset_n;
    assign bus.rf_s       = rf_s;
    assign bus.alu_s0     = alu_s0;
    assign bus.halted     = halted;
    assign bus.state_dbg  = state_q;
    assign bus.ir_out     = ir_q;
endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
//   Scoreboard bench: each scenario loads a ROM image, then pushes the
//   expected per-cycle output vector onto a queue; the vectors are popped and
//   compared against the DUT on the falling edge.
// ----------------------------------------------------------------------------
module tb_control_unit;
    localparam int PC_BITS = 7;
    localparam int ROM_N   = 1 << PC_BITS;

    localparam logic [3:0] INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, LOAD_A = 4'd3,
                           LOAD_B = 4'd4, STORE = 4'd5, EXEC = 4'd6, HALT = 4'd7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] rom [ROM_N];

    control_unit_if #(.PC_BITS(PC_BITS), .INSTR_BITS(16)) bus ();
    assign bus.im_data = rom[bus.im_addr];

    control_unit #(.PC_BITS(PC_BITS), .INSTR_BITS(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] q_exp [$];
    string       q_tag [$];

    // {state4, pc8, ir16, d_addr8, d_wr, ra4, ra_rd, rb4, rb_rd, wa4, w_wr, rf_s, alu3, halted}
    function automatic logic [63:0] pk(logic [3:0] st, int pc, logic [15:0] ir,
                                       logic [7:0] da, logic dw, logic [3:0] ra, logic rar,
                                       logic [3:0] rb, logic rbr, logic [3:0] wa, logic ww,
                                       logic rs, logic [2:0] alu, logic h);
        logic [7:0] p;
        p = 8'(pc);
        return {7'd0, st, p, ir, da, dw, ra, rar, rb, rbr, wa, ww, rs, alu, h};
    endfunction

    function automatic logic [63:0] e_idle(logic [3:0] st, int pc, logic [15:0] ir);
        return pk(st, pc, ir, 8'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0, 0);
    endfunction
    function automatic logic [63:0] e_halt(int pc, logic [15:0] ir);
        return pk(HALT, pc, ir, 8'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0, 1);
    endfunction
    function automatic logic [63:0] e_loada(int pc, logic [15:0] ir);
        return pk(LOAD_A, pc, ir, ir[11:4], 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 3'd0, 0);
    endfunction
    function automatic logic [63:0] e_loadb(int pc, logic [15:0] ir, logic ww);
        return pk(LOAD_B, pc, ir, ir[11:4], 0, 4'h0, 0, 4'h0, 0, ir[3:0], ww, 1, 3'd0, 0);
    endfunction
    function automatic logic [63:0] e_store(int pc, logic [15:0] ir);
        return pk(STORE, pc, ir, ir[11:4], 1, ir[3:0], 1, 4'h0, 0, 4'h0, 0, 0, 3'd0, 0);
    endfunction
    function automatic logic [63:0] e_exec(int pc, logic [15:0] ir, logic [2:0] alu);
        return pk(EXEC, pc, ir, 8'h0, 0, ir[11:8], 1, ir[7:4], 1, ir[3:0], 1, 0, alu, 0);
    endfunction

    function automatic logic [63:0] observed();
        return pk(bus.state_dbg, int'(bus.im_addr), bus.ir_out, bus.d_addr, bus.d_wr,
                  bus.rf_ra_addr, bus.rf_ra_rd, bus.rf_rb_addr, bus.rf_rb_rd,
                  bus.rf_w_addr, bus.rf_w_wr, bus.rf_s, bus.alu_s0, bus.halted);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] e);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // One pop/compare per falling edge until the scoreboard is empty
    task automatic drain();
        while (q_exp.size() > 0) begin
            @(negedge clk);
            chk(q_tag.pop_front(), observed(), q_exp.pop_front());
        end
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < ROM_N; i++) rom[i] = w;
    endtask

    // Hold reset across one rising edge, check INIT, then release
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(negedge clk);
        chk({tag, "_init"}, observed(), e_idle(INIT, 0, 16'h0));
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops  [7];
        logic [2:0]  alus [7];
        logic [15:0] w, prev;
        ops  = '{4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        alus = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};

        // ---- ADD R1,R2 -> R3, then HALT ----
        fill_rom(16'h5000);
        rom[0] = 16'h3123;
        do_reset("add");
        push("add_fetch",  e_idle(FETCH, 0, 16'h0));
        push("add_decode", e_idle(DECODE, 1, 16'h3123));
        push("add_exec",   e_exec(1, 16'h3123, 3'd1));
        push("add_fetch2", e_idle(FETCH, 1, 16'h3123));
        push("add_dec2",   e_idle(DECODE, 2, 16'h5000));
        for (int i = 0; i < 3; i++) push("add_halt", e_halt(2, 16'h5000));
        drain();

        // ---- LOAD R5 <- D[1A]: 4 cycles FETCH to FETCH ----
        fill_rom(16'h5000);
        rom[0] = 16'h11A5;
        do_reset("load");
        push("load_fetch",  e_idle(FETCH, 0, 16'h0));
        push("load_decode", e_idle(DECODE, 1, 16'h11A5));
        push("load_a",      e_loada(1, 16'h11A5));
        push("load_b",      e_loadb(1, 16'h11A5, 1'b1));
        push("load_fetch2", e_idle(FETCH, 1, 16'h11A5));
        push("load_dec2",   e_idle(DECODE, 2, 16'h5000));
        push("load_halt",   e_halt(2, 16'h5000));
        drain();

        // ---- STORE R7 -> D[80]: single d_wr cycle ----
        fill_rom(16'h5000);
        rom[0] = 16'h2807;
        do_reset("store");
        push("store_fetch",  e_idle(FETCH, 0, 16'h0));
        push("store_decode", e_idle(DECODE, 1, 16'h2807));
        push("store_st",     e_store(1, 16'h2807));
        push("store_fetch2", e_idle(FETCH, 1, 16'h2807));
        push("store_dec2",   e_idle(DECODE, 2, 16'h5000));
        push("store_halt",   e_halt(2, 16'h5000));
        drain();

        // ---- every ALU opcode, then illegal 1111 behaves as NOOP ----
        fill_rom(16'h5000);
        for (int k = 0; k < 7; k++) rom[k] = {ops[k], 12'h123};
        rom[7] = 16'hF000;
        do_reset("alu");
        prev = 16'h0;
        for (int k = 0; k < 7; k++) begin
            w = {ops[k], 12'h123};
            push($sformatf("alu%0d_fetch", k),  e_idle(FETCH, k, prev));
            push($sformatf("alu%0d_decode", k), e_idle(DECODE, k + 1, w));
            push($sformatf("alu%0d_exec", k),   e_exec(k + 1, w, alus[k]));
            prev = w;
        end
        push("ill_fetch",  e_idle(FETCH, 7, prev));
        push("ill_decode", e_idle(DECODE, 8, 16'hF000));
        push("ill_fetch2", e_idle(FETCH, 8, 16'hF000));
        push("ill_dec2",   e_idle(DECODE, 9, 16'h5000));
        push("ill_halt",   e_halt(9, 16'h5000));
        drain();

        // ---- ROM of NOOPs: PC wraps 127 -> 0 ----
        fill_rom(16'h0000);
        do_reset("wrap");
        for (int k = 0; k < ROM_N; k++) begin
            push("wrap_fetch",  e_idle(FETCH, k, 16'h0));
            push("wrap_decode", e_idle(DECODE, (k + 1) % ROM_N, 16'h0));
        end
        push("wrap_fetch0", e_idle(FETCH, 0, 16'h0));
        drain();

        // ---- HALT at ROM[3]: PC frozen, then reset out of HALT ----
        fill_rom(16'h0000);
        rom[3] = 16'h5000;
        do_reset("halt");
        for (int k = 0; k < 3; k++) begin
            push("halt_pre_fetch",  e_idle(FETCH, k, 16'h0));
            push("halt_pre_decode", e_idle(DECODE, k + 1, 16'h0));
        end
        push("halt_fetch",  e_idle(FETCH, 3, 16'h0));
        push("halt_decode", e_idle(DECODE, 4, 16'h5000));
        for (int i = 0; i < 22; i++) push("halt_frozen", e_halt(4, 16'h5000));
        drain();
        reset_n = 1'b0;
        #1;
        chk("rst_in_halt_now", observed(), e_halt(4, 16'h5000));
        @(negedge clk);
        chk("rst_in_halt_init", observed(), e_idle(INIT, 0, 16'h0));
        reset_n = 1'b1;

        // ---- reset during LOAD_B: write strobe drops immediately ----
        fill_rom(16'h5000);
        rom[0] = 16'h11A5;
        do_reset("rstld");
        push("rstld_fetch",  e_idle(FETCH, 0, 16'h0));
        push("rstld_decode", e_idle(DECODE, 1, 16'h11A5));
        push("rstld_a",      e_loada(1, 16'h11A5));
        push("rstld_b",      e_loadb(1, 16'h11A5, 1'b1));
        drain();
        reset_n = 1'b0;
        #1;
        chk("rst_in_loadb_now", observed(), e_loadb(1, 16'h11A5, 1'b0));
        @(negedge clk);
        chk("rst_in_loadb_init", observed(), e_idle(INIT, 0, 16'h0));
        reset_n = 1'b1;
        push("rstld_refetch", e_idle(FETCH, 0, 16'h0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
